// File: rtl/nios_system_desc_pkg.sv
// Shared types and constants for the descriptor fetcher: FSM states, descriptor word
// offsets, ctrl-byte bit positions and error codes.
package nios_system_desc_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      CHECK,
      PRESENT,
      WAIT_DONE,
      WB_CTRL,
      WB_LEN,
      NEXT,
      ERR
   } fetch_state_e;

   localparam logic [1:0] W_BUF  = 2'd0;
   localparam logic [1:0] W_NEXT = 2'd1;
   localparam logic [1:0] W_CTRL = 2'd2;
   localparam logic [1:0] W_LEN  = 2'd3;

   localparam int OWNED_BIT      = 7;
   localparam int STOP_AFTER_BIT = 6;
   localparam int EOP_BIT        = 0;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_LOOP     = 2'd2;
   localparam logic [1:0] ERR_STOP     = 2'd3;

   // Written-back ctrl byte hands ownership back to software.
   function automatic logic [7:0] clear_owned(input logic [7:0] ctrl);
      return ctrl & ~(8'h01 << OWNED_BIT);
   endfunction

endpackage

// File: rtl/nios_system_descriptor_fetcher_if.sv
// Avalon-MM bus between the descriptor fetcher (master) and the descriptor memory (slave).
interface nios_system_descriptor_fetcher_if #(
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0] m_address;
   logic              m_read;
   logic              m_write;
   logic [3:0]        m_byteenable;
   logic [31:0]       m_writedata;
   logic [31:0]       m_readdata;
   logic              m_waitrequest;
   logic              m_readdatavalid;

   modport master (
      output m_address, m_read, m_write, m_byteenable, m_writedata,
      input  m_readdata, m_waitrequest, m_readdatavalid
   );

   modport slave (
      input  m_address, m_read, m_write, m_byteenable, m_writedata,
      output m_readdata, m_waitrequest, m_readdatavalid
   );
endinterface

// File: rtl/nios_system_desc_rsp_capture.sv
// Tracks outstanding descriptor reads and stores the in-order responses into four word
// registers; strays arriving with nothing outstanding are dropped.
module nios_system_desc_rsp_capture (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             issue,
   input  logic             rsp_valid,
   input  logic [31:0]      rsp_data,
   output logic [3:0][31:0] words,
   output logic             last_rsp
);
   logic [2:0] outstanding;
   logic [1:0] rsp_cnt;
   logic       rsp_take;

   assign rsp_take = rsp_valid && (outstanding != 3'd0);
   assign last_rsp = rsp_take && (rsp_cnt == 2'd3);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         outstanding <= 3'd0;
         rsp_cnt     <= 2'd0;
         words       <= '0;
      end else begin
         outstanding <= outstanding + 3'(issue) - 3'(rsp_take);
         if (rsp_take) begin
            words[rsp_cnt] <= rsp_data;
            rsp_cnt        <= rsp_cnt + 2'd1;
         end
      end
   end
endmodule

// File: rtl/nios_system_descriptor_fetcher.sv
// Walks a linked list of 4-word DMA descriptors over Avalon-MM and feeds the MAC datapath.
// Build option DESC_FETCH_IRQ_EN adds irq/irq_ack.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | pipelined reads of w0..w3
// CHECK     | inspect OWNED_BY_HW
// PRESENT   | descriptor offered to datapath
// WAIT_DONE | waiting for datapath completion
// WB_CTRL   | write ctrl/status half of w2
// WB_LEN    | write actual length into w3
// NEXT      | count descriptor, follow next pointer
// ERR       | flag error, back to IDLE
module nios_system_descriptor_fetcher
   import nios_system_desc_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int MAX_CHAIN = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] head_ptr,
   input  logic        stop,
   output logic        busy,
   nios_system_descriptor_fetcher_if.master bus,
   output logic        desc_valid,
   input  logic        desc_ready,
   output logic [31:0] desc_buf_addr,
   output logic [15:0] desc_length,
   output logic        desc_eop,
   input  logic        done_valid,
   output logic        done_ready,
   input  logic [15:0] done_actual_len,
   input  logic [7:0]  done_status,
   output logic        chain_end,
   output logic        error,
   output logic [1:0]  err_code
`ifdef DESC_FETCH_IRQ_EN
   ,
   output logic        irq,
   input  logic        irq_ack
`endif
);
   localparam int CNT_W = $clog2(MAX_CHAIN + 1);

   fetch_state_e      state, state_nx;
   logic [31:0]       ptr;
   logic [2:0]        issue_cnt;
   logic [CNT_W-1:0]  desc_cnt, desc_cnt_inc;
   logic [15:0]       act_len;
   logic [7:0]        act_status;
   logic [1:0]        err_nx;
   logic              chain_end_nx;
   logic [3:0][31:0]  words;
   logic              last_rsp;
   logic              rd_req, wr_req, rd_accept;
   logic [1:0]        word_off;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [7:0]        ctrl;
   logic [31:0]       next_ptr;
   logic [ADDR_W-1:0] base;
   logic              unused_ok;

   assign ctrl         = words[W_CTRL][31:24];
   assign next_ptr     = words[W_NEXT];
   assign base         = ptr[ADDR_W+1:2];
   assign desc_cnt_inc = desc_cnt + CNT_W'(1);
   assign unused_ok    = ^{ptr, words[W_LEN], words[W_CTRL][23:16]};

   nios_system_desc_rsp_capture u_capture (
      .clk       (clk),
      .reset_n   (reset_n),
      .issue     (rd_accept),
      .rsp_valid (bus.m_readdatavalid),
      .rsp_data  (bus.m_readdata),
      .words     (words),
      .last_rsp  (last_rsp)
   );

   assign rd_accept        = rd_req && !bus.m_waitrequest;
   assign bus.m_read       = rd_req;
   assign bus.m_write      = wr_req;
   assign bus.m_byteenable = be;
   assign bus.m_writedata  = wdata;
   assign bus.m_address    = (rd_req || wr_req) ? base + ADDR_W'(word_off) : '0;

   assign busy          = (state != IDLE);
   assign desc_buf_addr = words[W_BUF];
   assign desc_length   = words[W_CTRL][15:0];
   assign desc_eop      = ctrl[EOP_BIT];

   always_comb begin
      state_nx     = state;
      chain_end_nx = 1'b0;
      err_nx       = ERR_NONE;
      rd_req       = 1'b0;
      wr_req       = 1'b0;
      word_off     = W_BUF;
      be           = 4'hF;
      wdata        = 32'h0;
      desc_valid   = 1'b0;
      done_ready   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               err_nx   = ERR_MISALIGN;
               state_nx = (head_ptr[1:0] != 2'b00) ? ERR : FETCH;
            end
         end
         FETCH: begin
            rd_req   = (issue_cnt != 3'd4);
            word_off = issue_cnt[1:0];
            if (last_rsp) state_nx = CHECK;
         end
         CHECK: begin
            if (!ctrl[OWNED_BIT]) begin
               state_nx     = IDLE;
               chain_end_nx = 1'b1;
            end else begin
               state_nx = PRESENT;
            end
         end
         PRESENT: begin
            // An abort wins over a same-cycle accept so nothing half-started reaches the MAC.
            if (stop) begin
               state_nx = ERR;
               err_nx   = ERR_STOP;
            end else begin
               desc_valid = 1'b1;
               if (desc_ready) state_nx = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            done_ready = 1'b1;
            if (done_valid) state_nx = WB_CTRL;
         end
         WB_CTRL: begin
            wr_req   = 1'b1;
            word_off = W_CTRL;
            be       = 4'b1100;
            wdata    = {clear_owned(ctrl), act_status, 16'h0};
            if (!bus.m_waitrequest) state_nx = WB_LEN;
         end
         WB_LEN: begin
            wr_req   = 1'b1;
            word_off = W_LEN;
            be       = 4'b0011;
            wdata    = {16'h0, act_len};
            if (!bus.m_waitrequest) state_nx = NEXT;
         end
         NEXT: begin
            if (ctrl[STOP_AFTER_BIT] || stop) begin
               state_nx     = IDLE;
               chain_end_nx = 1'b1;
            end else if (desc_cnt_inc == CNT_W'(MAX_CHAIN)) begin
               state_nx = ERR;
               err_nx   = ERR_LOOP;
            end else if (next_ptr[1:0] != 2'b00) begin
               state_nx = ERR;
               err_nx   = ERR_MISALIGN;
            end else begin
               state_nx = FETCH;
            end
         end
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         ptr        <= 32'h0;
         issue_cnt  <= 3'd0;
         desc_cnt   <= '0;
         act_len    <= 16'h0;
         act_status <= 8'h0;
         chain_end  <= 1'b0;
         error      <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         state     <= state_nx;
         chain_end <= chain_end_nx;
         issue_cnt <= (state == FETCH) ? issue_cnt + 3'(rd_accept) : 3'd0;
         if (state == IDLE && start) begin
            ptr      <= head_ptr;
            desc_cnt <= '0;
         end
         if (state == NEXT) begin
            ptr      <= next_ptr;
            desc_cnt <= desc_cnt_inc;
         end
         if (state == WAIT_DONE && done_valid) begin
            act_len    <= done_actual_len;
            act_status <= done_status;
         end
         if (state_nx == ERR) begin
            error    <= 1'b1;
            err_code <= err_nx;
         end else if (state == IDLE && start) begin
            error    <= 1'b0;
            err_code <= ERR_NONE;
         end
      end
   end

`ifdef DESC_FETCH_IRQ_EN
   always_ff @(posedge clk) begin
      if (!reset_n)                      irq <= 1'b0;
      else if (chain_end || state == ERR) irq <= 1'b1;
      else if (irq_ack)                  irq <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_nios_system_descriptor_fetcher.sv
// Directed bench for the descriptor fetcher against a 1024-word latency-1 memory model
// with configurable waitrequest stalls.
module tb_nios_system_descriptor_fetcher;
   logic        clk = 1'b0;
   logic        reset_n, start, stop, desc_ready, done_valid;
   logic [31:0] head_ptr;
   logic        busy, desc_valid, desc_eop, done_ready, chain_end, error;
   logic [31:0] desc_buf_addr;
   logic [15:0] desc_length, done_actual_len;
   logic [7:0]  done_status;
   logic [1:0]  err_code;
`ifdef DESC_FETCH_IRQ_EN
   logic        irq, irq_ack;
`endif

   nios_system_descriptor_fetcher_if #(.ADDR_W(10)) bus ();

   nios_system_descriptor_fetcher #(.ADDR_W(10), .MAX_CHAIN(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .head_ptr(head_ptr), .stop(stop),
      .busy(busy), .bus(bus), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_buf_addr(desc_buf_addr), .desc_length(desc_length), .desc_eop(desc_eop),
      .done_valid(done_valid), .done_ready(done_ready), .done_actual_len(done_actual_len),
      .done_status(done_status), .chain_end(chain_end), .error(error), .err_code(err_code)
`ifdef DESC_FETCH_IRQ_EN
      , .irq(irq), .irq_ack(irq_ack)
`endif
   );

   always #5 clk = ~clk;

   // memory model
   logic [31:0] mem [1024];
   logic [31:0] img [1024];
   logic        do_load = 1'b0;
   logic        wr_en = 1'b1;
   int          stall_cfg = 0;
   int          stall_cnt = 0;
   int          cyc = 0;
   logic        rdv = 1'b0;
   logic [31:0] rdata = 32'h0;

   assign bus.m_waitrequest   = (bus.m_read || bus.m_write) && (stall_cnt != stall_cfg);
   assign bus.m_readdatavalid = rdv;
   assign bus.m_readdata      = rdata;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      rdv <= 1'b0;
      if ((bus.m_read || bus.m_write) && bus.m_waitrequest) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
      if (do_load) mem <= img;
      else if (bus.m_write && !bus.m_waitrequest && wr_en)
         for (int b = 0; b < 4; b++)
            if (bus.m_byteenable[b]) mem[bus.m_address][b*8 +: 8] <= bus.m_writedata[b*8 +: 8];
      if (bus.m_read && !bus.m_waitrequest) begin
         rdv   <= 1'b1;
         rdata <= mem[bus.m_address];
      end
   end

   // bus / datapath monitor
   int          rd_ops = 0, wr_ops = 0, pres = 0, ce_cnt = 0, viol = 0;
   int          last_rdv_cyc = 0, ce_cyc = 0;
   logic [31:0] pres_buf [$];
   logic [15:0] pres_len [$];
   logic        pres_eop [$];
   int          rd_addr_q [$];
   logic        p_stall = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
   logic [9:0]  p_addr = '0;
   logic [3:0]  p_be = '0;
   logic [31:0] p_data = '0;

   always @(negedge clk) begin
      if (bus.m_read && bus.m_write) viol++;
      if (p_stall && (bus.m_address !== p_addr || bus.m_read !== p_rd || bus.m_write !== p_wr ||
                      bus.m_byteenable !== p_be || bus.m_writedata !== p_data)) viol++;
      p_stall = (bus.m_read || bus.m_write) && bus.m_waitrequest;
      p_addr  = bus.m_address;
      p_rd    = bus.m_read;
      p_wr    = bus.m_write;
      p_be    = bus.m_byteenable;
      p_data  = bus.m_writedata;
      if (bus.m_read && !bus.m_waitrequest) begin
         rd_ops++;
         rd_addr_q.push_back(int'(bus.m_address));
      end
      if (bus.m_write && !bus.m_waitrequest) wr_ops++;
      if (desc_valid && desc_ready) begin
         pres++;
         pres_buf.push_back(desc_buf_addr);
         pres_len.push_back(desc_length);
         pres_eop.push_back(desc_eop);
      end
      if (bus.m_readdatavalid) last_rdv_cyc = cyc;
      if (chain_end) begin
         ce_cnt++;
         ce_cyc = cyc;
      end
   end

   int checks = 0, errors = 0;
   int b_rd, b_wr, b_pres, b_ce;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_rd = rd_ops; b_wr = wr_ops; b_pres = pres; b_ce = ce_cnt;
   endtask

   task automatic load_img(input int which);
      for (int i = 0; i < 1024; i++) img[i] = 32'h0;
      case (which)
         1: begin
            img[0] = 32'h1000_0000; img[1] = 32'h0000_0010; img[2]  = 32'h8000_0040;
            img[4] = 32'h2000_0000; img[5] = 32'h0000_0020; img[6]  = 32'h8100_0080;
            img[8] = 32'h3000_0000; img[9] = 32'h0000_0030; img[10] = 32'hC000_00C0;
         end
         2: begin img[64] = 32'h7000_0000; img[65] = 32'h8000_0000; img[66] = 32'h0000_0020; end
         3: begin img[128] = 32'h5000_0000; img[129] = 32'h0000_0200; img[130] = 32'h8000_0010; end
         default: begin img[192] = 32'h6000_0000; img[193] = 32'h0000_0302; img[194] = 32'h8000_0004; end
      endcase
      @(negedge clk); do_load = 1'b1;
      @(negedge clk); do_load = 1'b0;
   endtask

   task automatic run_chain(input logic [31:0] hp);
      int n = 0;
      @(negedge clk); head_ptr = hp; start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (busy && n < 1000) begin @(negedge clk); n++; end
      check("run_timeout", 32'(busy), 32'h0);
      @(negedge clk);
   endtask

   logic [31:0] exp1 [12] = '{32'h1000_0000, 32'h0000_0010, 32'h0011_0040, 32'h0000_05EE,
                              32'h2000_0000, 32'h0000_0020, 32'h0111_0080, 32'h0000_05EE,
                              32'h3000_0000, 32'h0000_0030, 32'h4011_00C0, 32'h0000_05EE};

   initial begin
      int n;
      reset_n = 1'b0; start = 1'b0; head_ptr = 32'h0; stop = 1'b0;
      desc_ready = 1'b1; done_valid = 1'b1; done_actual_len = 16'h05EE; done_status = 8'h11;
`ifdef DESC_FETCH_IRQ_EN
      irq_ack = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      check("rst_busy", 32'(busy), 0);
      check("rst_read", 32'(bus.m_read), 0);
      check("rst_write", 32'(bus.m_write), 0);
      check("rst_be", 32'(bus.m_byteenable), 32'hF);
      check("rst_addr", 32'(bus.m_address), 0);
      check("rst_error", 32'(error), 0);
      check("rst_err_code", 32'(err_code), 0);
      check("rst_desc_valid", 32'(desc_valid), 0);
      check("rst_done_ready", 32'(done_ready), 0);
      check("rst_chain_end", 32'(chain_end), 0);

      // three-descriptor chain, STOP_AFTER on the third
      load_img(1); snap(); run_chain(32'h0);
      check("t1_reads", 32'(rd_ops - b_rd), 12);
      check("t1_writes", 32'(wr_ops - b_wr), 6);
      check("t1_pres", 32'(pres - b_pres), 3);
      check("t1_chain_end", 32'(ce_cnt - b_ce), 1);
      check("t1_buf0", pres_buf[b_pres], 32'h1000_0000);
      check("t1_len0", 32'(pres_len[b_pres]), 32'h40);
      check("t1_eop0", 32'(pres_eop[b_pres]), 0);
      check("t1_eop1", 32'(pres_eop[b_pres+1]), 1);
      check("t1_buf2", pres_buf[b_pres+2], 32'h3000_0000);
      check("t1_error", 32'(error), 0);
      for (int i = 0; i < 12; i++) check($sformatf("t1_mem%0d", i), mem[i], exp1[i]);

      // reset in the middle of a fetch burst
      load_img(1);
      @(negedge clk); head_ptr = 32'h0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_read", 32'(bus.m_read), 0);

      // stop while presented and not yet accepted
      desc_ready = 1'b0; snap();
      @(negedge clk); head_ptr = 32'h0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!desc_valid && n < 100) begin @(negedge clk); n++; end
      check("abort_present", 32'(desc_valid), 1);
      stop = 1'b1; #1;
      check("abort_drop_valid", 32'(desc_valid), 0);
      n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      stop = 1'b0; desc_ready = 1'b1;
      check("abort_error", 32'(error), 1);
      check("abort_code", 32'(err_code), 3);
      check("abort_writes", 32'(wr_ops - b_wr), 0);
      check("abort_pres", 32'(pres - b_pres), 0);

      // not-owned head via a wrapped pointer; start also clears the sticky error
      load_img(2); snap(); run_chain(32'h8000_0100);
      check("t2_reads", 32'(rd_ops - b_rd), 4);
      check("t2_first_addr", 32'(rd_addr_q[b_rd]), 64);
      check("t2_writes", 32'(wr_ops - b_wr), 0);
      check("t2_pres", 32'(pres - b_pres), 0);
      check("t2_chain_end", 32'(ce_cnt - b_ce), 1);
      check("t2_ce_latency", 32'(ce_cyc - last_rdv_cyc), 2);
      check("t2_error_cleared", 32'(error), 0);
      check("t2_code_cleared", 32'(err_code), 0);

      // misaligned head, then a clean restart
      snap(); run_chain(32'h0000_0006);
      check("t4_error", 32'(error), 1);
      check("t4_code", 32'(err_code), 1);
      check("t4_busops", 32'((rd_ops - b_rd) + (wr_ops - b_wr)), 0);
      run_chain(32'h0000_0100);
      check("t4_error_clr", 32'(error), 0);
      check("t4_code_clr", 32'(err_code), 0);

      // self-loop hits the chain limit (writes discarded so ownership persists)
      load_img(3); wr_en = 1'b0; snap(); run_chain(32'h0000_0200);
      wr_en = 1'b1;
      check("t5_writes", 32'(wr_ops - b_wr), 8);
      check("t5_reads", 32'(rd_ops - b_rd), 16);
      check("t5_pres", 32'(pres - b_pres), 4);
      check("t5_error", 32'(error), 1);
      check("t5_code", 32'(err_code), 2);
      check("t5_chain_end", 32'(ce_cnt - b_ce), 0);

      // misaligned next pointer after one full descriptor
      load_img(4); snap(); run_chain(32'h0000_0300);
      check("mnext_writes", 32'(wr_ops - b_wr), 2);
      check("mnext_code", 32'(err_code), 1);
      check("mnext_mem_w2", mem[194], 32'h0011_0004);

`ifdef DESC_FETCH_IRQ_EN
      @(negedge clk); irq_ack = 1'b1;
      @(negedge clk); irq_ack = 1'b0;
      check("irq_acked", 32'(irq), 0);
`endif
      // three-cycle stall on every bus op
      load_img(1); stall_cfg = 3; snap(); run_chain(32'h0);
      stall_cfg = 0;
      check("t6_reads", 32'(rd_ops - b_rd), 12);
      check("t6_writes", 32'(wr_ops - b_wr), 6);
      check("t6_chain_end", 32'(ce_cnt - b_ce), 1);
      for (int i = 0; i < 12; i++) check($sformatf("t6_mem%0d", i), mem[i], exp1[i]);
      check("bus_stability", 32'(viol), 0);
`ifdef DESC_FETCH_IRQ_EN
      check("irq_set", 32'(irq), 1);
      repeat (3) @(negedge clk);
      check("irq_held", 32'(irq), 1);
      irq_ack = 1'b1;
      @(negedge clk); irq_ack = 1'b0;
      check("irq_cleared", 32'(irq), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
